// File: rtl/frog_status_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frog_status_if                                               |
// | Description : Frame, hop, hazard and status signals of the frog tracker.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface frog_status_if;
  logic       frame_clk;
  logic       frog_respawn;
  logic       hop_up;
  logic       hop_down;
  logic       hop_left;
  logic       hop_right;
  logic       car_hit;
  logic       on_log;
  logic [3:0] log_dx;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       isDead;
  logic       isAlive;
  logic       dying;

  modport master (
    output frame_clk, frog_respawn, hop_up, hop_down, hop_left, hop_right,
           car_hit, on_log, log_dx,
    input  frog_x, frog_y, isDead, isAlive, dying
  );

  modport slave (
    input  frame_clk, frog_respawn, hop_up, hop_down, hop_left, hop_right,
           car_hit, on_log, log_dx,
    output frog_x, frog_y, isDead, isAlive, dying
  );
endinterface
`default_nettype wire

// File: rtl/frog_status.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frog_status                                                  |
// | Description : Per-frame frog position and life/death status tracker.       |
// |               Optional death animation: define FROG_DEATH_ANIM_EN.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module frog_status #(
  parameter int X_START   = 304,
  parameter int Y_START   = 448,
  parameter int X_MAX     = 608,
  parameter int Y_GOAL    = 0,
  parameter int HOP       = 32,
  parameter int WATER_TOP = 64,
  parameter int WATER_BOT = 224
`ifdef FROG_DEATH_ANIM_EN
  ,
  parameter int DEATH_FRAMES = 30
`endif
) (
  input  logic         Clk,
  input  logic         Reset_n,
  frog_status_if.slave bus
);

  localparam logic [9:0]        c_x_start_pos = 10'(X_START);
  localparam logic [9:0]        c_y_start_pos = 10'(Y_START);
  localparam logic [9:0]        c_y_home_pos  = 10'(Y_GOAL);
  localparam logic signed [10:0] c_y_start    = 11'(Y_START);
  localparam logic signed [10:0] c_y_goal     = 11'(Y_GOAL);
  localparam logic signed [10:0] c_x_max      = 11'(X_MAX);
  localparam logic signed [10:0] c_hop        = 11'(HOP);
  localparam logic signed [10:0] c_water_top  = 11'(WATER_TOP);
  localparam logic signed [10:0] c_water_bot  = 11'(WATER_BOT);
  localparam logic signed [10:0] c_zero       = 11'sd0;

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_play  = 3'd1;
  localparam logic [2:0] c_dead  = 3'd3;
  localparam logic [2:0] c_home  = 3'd4;
`ifdef FROG_DEATH_ANIM_EN
  localparam logic [2:0] c_dying = 3'd2;
  localparam int         c_cnt_w = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEATH_FRAMES - 1);
`endif

  logic       r_fc_meta;
  logic       r_fc_sync;
  logic       r_fc_prev;
  logic       r_tick;
  logic       r_hop_prev;
  logic [2:0] r_state;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_dead;
  logic       r_alive;
`ifdef FROG_DEATH_ANIM_EN
  logic               r_dying;
  logic [c_cnt_w-1:0] r_cnt;
`endif

  logic signed [10:0] w_x;
  logic signed [10:0] w_y;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_x_drift;
  logic signed [10:0] w_up_y;
  logic signed [10:0] w_down_y;
  logic signed [10:0] w_left_x;
  logic signed [10:0] w_right_x;
  logic               w_in_river;
  logic               w_drift_out;
  logic               w_die;
  logic               w_any_hop;
  logic               w_hop_ok;
  logic [9:0]         w_x_new;
  logic [9:0]         w_y_new;

  // frame_clk is asynchronous; the edge detect is registered so the
  // update lands three Clk edges after the sampled rise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fc_meta <= 1'b0;
      r_fc_sync <= 1'b0;
      r_fc_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_fc_meta <= bus.frame_clk;
      r_fc_sync <= r_fc_meta;
      r_fc_prev <= r_fc_sync;
      r_tick    <= r_fc_sync & ~r_fc_prev;
    end
  end

  assign w_any_hop = bus.hop_up | bus.hop_down | bus.hop_left | bus.hop_right;
  assign w_hop_ok  = w_any_hop & ~r_hop_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hop_prev <= 1'b0;
    end else if (r_tick) begin
      r_hop_prev <= w_any_hop;
    end
  end

  assign w_x         = $signed({1'b0, r_x});
  assign w_y         = $signed({1'b0, r_y});
  assign w_dx        = {{7{bus.log_dx[3]}}, bus.log_dx};
  assign w_in_river  = (w_y >= c_water_top) && (w_y < c_water_bot);
  assign w_x_drift   = w_in_river ? (w_x + w_dx) : w_x;
  assign w_drift_out = w_in_river && ((w_x_drift < c_zero) || (w_x_drift > c_x_max));
  assign w_die       = bus.car_hit | (w_in_river & ~bus.on_log) | w_drift_out;

  assign w_up_y    = w_y - c_hop;
  assign w_down_y  = w_y + c_hop;
  assign w_left_x  = w_x_drift - c_hop;
  assign w_right_x = w_x_drift + c_hop;

  // Only the highest-priority hop is considered; if it leaves the field it is dropped.
  always_comb begin
    w_x_new = w_x_drift[9:0];
    w_y_new = r_y;
    if (w_hop_ok) begin
      if (bus.hop_up) begin
        if (w_up_y >= c_y_goal) w_y_new = w_up_y[9:0];
      end else if (bus.hop_down) begin
        if (w_down_y <= c_y_start) w_y_new = w_down_y[9:0];
      end else if (bus.hop_left) begin
        if (w_left_x >= c_zero) w_x_new = w_left_x[9:0];
      end else begin
        if (w_right_x <= c_x_max) w_x_new = w_right_x[9:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= c_idle;
      r_x     <= c_x_start_pos;
      r_y     <= c_y_start_pos;
      r_dead  <= 1'b0;
      r_alive <= 1'b0;
`ifdef FROG_DEATH_ANIM_EN
      r_dying <= 1'b0;
      r_cnt   <= '0;
`endif
    end else if (bus.frog_respawn) begin
      r_state <= c_play;
      r_x     <= c_x_start_pos;
      r_y     <= c_y_start_pos;
      r_dead  <= 1'b0;
      r_alive <= 1'b0;
`ifdef FROG_DEATH_ANIM_EN
      r_dying <= 1'b0;
      r_cnt   <= '0;
`endif
    end else if (r_tick) begin
      case (r_state)
        c_play: begin
          if (w_die) begin
`ifdef FROG_DEATH_ANIM_EN
            r_state <= c_dying;
            r_dying <= 1'b1;
            r_cnt   <= '0;
`else
            r_state <= c_dead;
            r_dead  <= 1'b1;
`endif
          end else begin
            r_x <= w_x_new;
            r_y <= w_y_new;
            if (w_y_new == c_y_home_pos) begin
              r_state <= c_home;
              r_alive <= 1'b1;
            end
          end
        end
`ifdef FROG_DEATH_ANIM_EN
        c_dying: begin
          if (r_cnt == c_cnt_last) begin
            r_state <= c_dead;
            r_dying <= 1'b0;
            r_dead  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.frog_x  = r_x;
  assign bus.frog_y  = r_y;
  assign bus.isDead  = r_dead;
  assign bus.isAlive = r_alive;
`ifdef FROG_DEATH_ANIM_EN
  assign bus.dying   = r_dying;
`else
  assign bus.dying   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frog_status.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_frog_status                                               |
// | Description : Directed vector bench for frog_status (FROG_DEATH_ANIM_EN    |
// |               selects the animated death expectations).                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_frog_status;

  typedef struct {
    logic [3:0] hops;   // {up, down, left, right}
    logic       car;
    logic       log_on;
    logic [3:0] dx;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset_n;
  frog_status_if bus ();

  frog_status dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int         n_vec;
  int         n_bad;
  logic [9:0] ex;
  logic [9:0] ey;
  logic       ed;
  logic       ea;
  logic       edy;
  logic [22:0] cur;
  vec_t       tbl[$];

  function automatic logic [22:0] act();
    return {bus.frog_x, bus.frog_y, bus.isDead, bus.isAlive, bus.dying};
  endfunction

  task automatic report(input string name, input logic [22:0] want);
    logic [22:0] got;
    got = act();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d dead=%b alive=%b dying=%b, expected x=%0d y=%0d dead=%b alive=%b dying=%b",
               name, got[22:13], got[12:3], got[2], got[1], got[0],
               want[22:13], want[12:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic chk(input string name);
    cur = {ex, ey, ed, ea, edy};
    report(name, cur);
  endtask

  // One frame: inputs set while frame_clk is low, then a rise; outputs must
  // hold through edge N+2 and take the new values at edge N+3.
  task automatic step(input logic [3:0] h, input logic car, input logic log_on,
                      input logic [3:0] dx, input string name);
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    {bus.hop_up, bus.hop_down, bus.hop_left, bus.hop_right} = h;
    bus.car_hit = car;
    bus.on_log  = log_on;
    bus.log_dx  = dx;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    report({name, "_early"}, cur);
    @(posedge Clk);
    #1;
    chk(name);
  endtask

  task automatic die_step(input logic [3:0] h, input logic car, input logic log_on,
                          input logic [3:0] dx, input string name);
`ifdef FROG_DEATH_ANIM_EN
    edy = 1'b1;
    step(h, car, log_on, dx, name);
    for (int i = 1; i < 30; i++) step(4'b0000, 1'b0, 1'b0, 4'h0, "dying_hold");
    edy = 1'b0;
    ed  = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 4'h0, {name, "_dead"});
`else
    ed = 1'b1;
    step(h, car, log_on, dx, name);
`endif
  endtask

  task automatic respawn(input string name);
    @(negedge Clk);
    bus.frog_respawn = 1'b1;
    @(posedge Clk);
    #1;
    ex = 10'd304; ey = 10'd448; ed = 1'b0; ea = 1'b0; edy = 1'b0;
    chk(name);
    @(negedge Clk);
    bus.frog_respawn = 1'b0;
  endtask

  task automatic climb(input logic [9:0] target);
    while (ey > target) begin
      ey = ey - 10'd32;
      step(4'b1000, 1'b0, 1'b1, 4'h0, "climb");
      step(4'b0000, 1'b0, 1'b1, 4'h0, "climb_rel");
    end
  endtask

  task automatic add(input logic [3:0] h, input logic car, input logic log_on,
                     input logic [3:0] dx, input logic [9:0] x, input logic [9:0] y);
    vec_t v;
    v.hops = h; v.car = car; v.log_on = log_on; v.dx = dx; v.x = x; v.y = y;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    Reset_n          = 1'b0;
    bus.frame_clk    = 1'b0;
    bus.frog_respawn = 1'b0;
    bus.hop_up       = 1'b0;
    bus.hop_down     = 1'b0;
    bus.hop_left     = 1'b0;
    bus.hop_right    = 1'b0;
    bus.car_hit      = 1'b0;
    bus.on_log       = 1'b0;
    bus.log_dx       = 4'h0;

    // hops, car, on_log, log_dx -> expected x, y  (start at 304,448 in PLAY)
    add(4'b1000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);  // first press hops
    add(4'b1000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);  // held: no hop
    add(4'b1000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);
    add(4'b0100, 1'b0, 1'b0, 4'h0, 10'd304, 10'd448);
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd448);
    add(4'b0010, 1'b0, 1'b0, 4'h0, 10'd272, 10'd448);
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd272, 10'd448);
    add(4'b0001, 1'b0, 1'b0, 4'h0, 10'd304, 10'd448);
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd448);
    add(4'b0100, 1'b0, 1'b0, 4'h0, 10'd304, 10'd448);  // below start: discarded
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd448);
    add(4'b1010, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);  // up beats left
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);
    add(4'b0001, 1'b0, 1'b0, 4'h0, 10'd336, 10'd416);
    add(4'b1001, 1'b0, 1'b0, 4'h0, 10'd336, 10'd416);  // new key while one held
    add(4'b0000, 1'b0, 1'b1, 4'hD, 10'd336, 10'd416);  // no drift outside river
    add(4'b0010, 1'b0, 1'b0, 4'h5, 10'd304, 10'd416);
    add(4'b0000, 1'b0, 1'b0, 4'h0, 10'd304, 10'd416);

    repeat (2) @(posedge Clk);
    #1;
    ex = 10'd304; ey = 10'd448; ed = 1'b0; ea = 1'b0; edy = 1'b0;
    chk("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    step(4'b0000, 1'b1, 1'b0, 4'h0, "idle_tick");
    respawn("respawn");

    foreach (tbl[i]) begin
      ex = tbl[i].x;
      ey = tbl[i].y;
      step(tbl[i].hops, tbl[i].car, tbl[i].log_on, tbl[i].dx, $sformatf("vec%0d", i));
    end

    // Edge clamping: walk to (0,448) through the river.
    climb(10'd192);
    ex = 10'd296; step(4'b0000, 1'b0, 1'b1, 4'h8, "drift_m8");
    ex = 10'd288; step(4'b0000, 1'b0, 1'b1, 4'h8, "drift_m8");
    for (int i = 0; i < 9; i++) begin
      ex = ex - 10'd32;
      step(4'b0010, 1'b0, 1'b1, 4'h0, "walk_left");
      step(4'b0000, 1'b0, 1'b1, 4'h0, "walk_rel");
    end
    for (int i = 0; i < 8; i++) begin
      ey = ey + 10'd32;
      step(4'b0100, 1'b0, 1'b1, 4'h0, "walk_down");
      step(4'b0000, 1'b0, 1'b1, 4'h0, "walk_rel");
    end
    step(4'b0010, 1'b0, 1'b0, 4'h0, "clamp_left");
    step(4'b0000, 1'b0, 1'b0, 4'h0, "clamp_rel");
    step(4'b0100, 1'b0, 1'b0, 4'h0, "clamp_down");
    step(4'b0000, 1'b0, 1'b0, 4'h0, "clamp_rel");

    // River drift to x=2, then off the left bank.
    ex = 10'd32; step(4'b0001, 1'b0, 1'b0, 4'h0, "hop_right");
    step(4'b0000, 1'b0, 1'b0, 4'h0, "hop_rel");
    climb(10'd192);
    for (int i = 0; i < 10; i++) begin
      ex = ex - 10'd3;
      step(4'b0000, 1'b0, 1'b1, 4'hD, "drift_m3");
    end
    die_step(4'b0000, 1'b0, 1'b1, 4'hD, "drift_off_bank");
    step(4'b1000, 1'b1, 1'b0, 4'h0, "dead_ignores");

    respawn("respawn2");
    step(4'b0000, 1'b0, 1'b0, 4'h0, "rel");
    climb(10'd192);
    die_step(4'b0000, 1'b0, 1'b0, 4'h0, "river_no_log");

    respawn("respawn3");
    step(4'b0000, 1'b0, 1'b0, 4'h0, "rel");
    die_step(4'b1000, 1'b1, 1'b0, 4'h0, "car_hit");

    // Reaching home, then a respawn landing on the same cycle as a tick.
    respawn("respawn4");
    step(4'b0000, 1'b0, 1'b0, 4'h0, "rel");
    climb(10'd32);
    ey = 10'd0; ea = 1'b1;
    step(4'b1000, 1'b0, 1'b0, 4'h0, "home");
    step(4'b0000, 1'b1, 1'b0, 4'h0, "home_hold");

    @(negedge Clk);
    bus.frame_clk = 1'b0;
    bus.hop_up    = 1'b1;
    bus.car_hit   = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    bus.frog_respawn = 1'b1;
    @(posedge Clk);
    #1;
    ex = 10'd304; ey = 10'd448; ed = 1'b0; ea = 1'b0; edy = 1'b0;
    chk("respawn_on_tick");
    @(negedge Clk);
    bus.frog_respawn = 1'b0;
    bus.hop_up       = 1'b0;
    bus.car_hit      = 1'b0;
    step(4'b0000, 1'b0, 1'b0, 4'h0, "rel");
    ey = 10'd416;
    step(4'b1000, 1'b0, 1'b0, 4'h0, "play_after_respawn");

    // Asynchronous reset while the frog is dying (dead without the animation).
`ifdef FROG_DEATH_ANIM_EN
    edy = 1'b1;
`else
    ed = 1'b1;
`endif
    step(4'b0000, 1'b1, 1'b0, 4'h0, "car_before_reset");
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    ex = 10'd304; ey = 10'd448; ed = 1'b0; ea = 1'b0; edy = 1'b0;
    chk("async_reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    step(4'b1000, 1'b1, 1'b0, 4'h0, "idle_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frog_status.md
# frog_status

Per-frame frog state tracker for the Frogger datapath. Consumes the frame tick, decoded hop requests and hazard flags from the sprite/collision logic, moves the frog, and produces the `isDead`/`isAlive` status that the game-clock controller consumes. `frog_respawn` is the return path from that controller and re-arms the frog. Frog position also drives the frog sprite renderer.

## Interface
- `X_START`, 304: respawn column (px)
- `Y_START`, 448: respawn row (px)
- `X_MAX`, 608: rightmost legal column; leftmost is 0
- `Y_GOAL`, 0: home row
- `HOP`, 32: hop distance (px)
- `WATER_TOP`, 64; `WATER_BOT`, 224: river band is `WATER_TOP <= y < WATER_BOT`
- `DEATH_FRAMES`, 30: death animation length in frames
- `Clk` input 1: system clock
- `Reset_n` input 1: asynchronous, active-low reset
- `frame_clk` input 1: VGA vertical sync level, asynchronous to `Clk`
- `frog_respawn` input 1: one-`Clk` pulse from the game controller
- `hop_up`, `hop_down`, `hop_left`, `hop_right` input 1 each: decoded key levels
- `car_hit` input 1: frog overlaps a car this frame
- `on_log` input 1: frog overlaps a log this frame
- `log_dx` input 4: signed drift of the log under the frog (px/frame)
- `frog_x`, `frog_y` output 10 each: frog top-left position
- `isDead` output 1: level, frog dead
- `isAlive` output 1: level, frog reached home
- `dying` output 1: death animation in progress

## Operation
- **Tick generation:** `frame_clk` passes through a 2-FF synchronizer. A rising-edge detect then produces `tick`, one `Clk` wide.
- **State machine:** IDLE, PLAY, DYING, DEAD, HOME.
- **Reset:** state is IDLE, `frog_x`=`X_START`, `frog_y`=`Y_START`, and all flags are 0.
- **Respawn:** `frog_respawn` moves any state to PLAY, sets the position to start, and clears `isDead`, `isAlive`, `dying` and the death counter. Respawn wins over a simultaneous `tick`.
- **IDLE:** ignores ticks.
- **PLAY:** on each `tick`, evaluated in this order against the current, pre-update position:
  1. `car_hit`=1 → DYING.
  2. In the river band with `on_log`=0 → DYING.
  3. In the river band: `x' = x + sign_extend(log_dx)`, computed in 11-bit signed. If `x' < 0` or `x' > X_MAX` → DYING and the position is not updated.
  4. Hop, only if one is accepted (see hop rules), priority up > down > left > right. A hop whose result would leave [0, `X_MAX`] × [`Y_GOAL`, `Y_START`] is discarded. Otherwise it is applied to `x'`/`y`.
  5. Resulting `y == Y_GOAL` → HOME.
- **Hop rules:**
  - A hop is accepted only if at least one hop input is high at this `tick` and all were low at the previous `tick`. Holding a key yields one hop.
  - A hop sampled on a tick that enters DYING is dropped.
- **DYING:** `dying`=1. The counter increments per `tick`. On the `DEATH_FRAMES`-th tick → DEAD, `dying`=0. Position is frozen.
- **DEAD:** `isDead`=1 until respawn.
- **HOME:** `isAlive`=1 until respawn.
- **Ignored inputs:** hazard and hop inputs are ignored outside PLAY.

## Timing
- A `frame_clk` rise sampled at `Clk` edge N gives `tick` high during cycle N+2. State and position update at edge N+3.
- `isDead`, `isAlive`, `dying`, `frog_x` and `frog_y` are registered and change only at those update edges or one edge after `frog_respawn` is sampled.
- `frog_respawn` sampled at edge M: outputs reflect respawn after edge M.
- **Death latency:** with the animation enabled, `isDead` rises exactly `DEATH_FRAMES` ticks after the tick that entered DYING.
- **Mid-operation reset:** `Reset_n` low forces reset values immediately and asynchronously, including the synchronizer and edge history.

## Configuration
- `FROG_DEATH_ANIM_EN` defined: DYING state and counter as described. `dying` pulses high for `DEATH_FRAMES` frames.
- `FROG_DEATH_ANIM_EN` undefined:
  - No DYING state and no counter.
  - Every death condition goes directly to DEAD at the same update edge, so `isDead` rises 3 `Clk` after the frame edge.
  - `dying` is tied to 0.

## Test plan
- **Reset and respawn:** reset, pulse `frog_respawn` → (304, 448) in PLAY. Hold `hop_up` for 3 ticks → `frog_y`=416 after the first tick only.
- **Edge clamping:** from (0, 448), `hop_left` then `hop_down` → both discarded, position stays (0, 448).
- **Car collision:** `car_hit`=1 on a tick → `dying`=1. `isDead`=1 after 30 more ticks, or 3 `Clk` after the frame edge with the macro undefined.
- **River:** at y=192 with `on_log`=1 and `log_dx`=-3 → x decreases 3/tick. At x=2, the next tick → DYING. At y=192 with `on_log`=0 → DYING.
- **Reaching home:** hop up from y=32 → `frog_y`=0 and `isAlive`=1. Respawn pulse coincident with a tick → PLAY at start, `isAlive`=0.
- **Async reset mid-animation:** assert `Reset_n` low in DYING → immediate IDLE, outputs at reset values.
